fast_score_sched: RTL and testbench

Sequencing controller for the shared FAST corner-score datapath. The datapath is a 5-stage pipelined adder tree plus max over 16 bright and 16 dark differences, with a clock enable and a 13-bit score output.
- Accepts candidate pixels on a valid/ready stream and drives the datapath clock enable.
- Carries coordinate and frame-marker tags alongside the datapath, aligned to its fixed latency.
- Applies stall/backpressure and a configurable minimum-score qualification.
- Emits scored results toward non-max suppression and keeps per-frame corner statistics.

---
 rtl/fast_pkg.sv | 26 ++
 rtl/fast_tag_pipe.sv | 43 ++++
 rtl/fast_score_sched.sv | 111 +++++++++++
 tb/tb_fast_score_sched.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fast_pkg.sv
// Shared types and constants for the FAST corner-score scheduling slice.
package fast_pkg;

  localparam int unsigned SCORE_W  = 13;
  localparam int unsigned FAST_LAT = 5;
  localparam int unsigned TAG_XW   = 11;
  localparam int unsigned TAG_YW   = 11;

  typedef struct packed {
    logic              is_corner;
    logic [TAG_XW-1:0] x;
    logic [TAG_YW-1:0] y;
    logic              sof;
    logic              eof;
  } fast_tag_t;

  typedef struct packed {
    logic [SCORE_W-1:0] score;
    logic               corner;
    logic [TAG_XW-1:0]  x;
    logic [TAG_YW-1:0]  y;
    logic               sof;
    logic               eof;
  } fast_result_t;

endpackage

// File: rtl/fast_tag_pipe.sv
// Enable-gated shift register carrying valid + tag alongside the score datapath.
module fast_tag_pipe
  import fast_pkg::*;
#(
  parameter int unsigned LAT = FAST_LAT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           in_vld,
  input  fast_tag_t      in_tag,
  output logic [LAT-1:0] vld,
  output fast_tag_t      out_tag
);

  logic [LAT-1:0] vld_q, vld_d;
  fast_tag_t      tag_q [LAT];
  fast_tag_t      tag_d [LAT];

  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    if (en) begin
      vld_d[0] = in_vld;
      tag_d[0] = in_tag;
      for (int i = 1; i < LAT; i++) begin
        vld_d[i] = vld_q[i-1];
        tag_d[i] = tag_q[i-1];
      end
    end
  end

  // Tag payload needs no reset: it is only observed when its valid bit is set.
  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
    tag_q <= tag_d;
  end

  assign vld     = vld_q;
  assign out_tag = tag_q[LAT-1];

endmodule

// File: rtl/fast_score_sched.sv
// Sequencer for the shared FAST score datapath: clock enable, tag alignment,
// backpressure, min-score qualification and per-frame corner counting.
module fast_score_sched
  import fast_pkg::*;
#(
  parameter int unsigned LAT     = FAST_LAT,
  parameter int unsigned XW      = TAG_XW,
  parameter int unsigned YW      = TAG_YW,
  parameter int unsigned SCORE_W = fast_pkg::SCORE_W,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_is_corner,
  input  logic [XW-1:0]      in_x,
  input  logic [YW-1:0]      in_y,
  input  logic               in_sof,
  input  logic               in_eof,
  input  logic [SCORE_W-1:0] cfg_min_score,
  output logic               score_ce,
  input  logic [SCORE_W-1:0] score_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SCORE_W-1:0] out_score,
  output logic               out_corner,
  output logic [XW-1:0]      out_x,
  output logic [YW-1:0]      out_y,
  output logic               out_sof,
  output logic               out_eof,
  output logic [CNT_W-1:0]   frame_corners,
  output logic               frame_done
);

  logic         stall, fire;
  logic [LAT-1:0] vld;
  fast_tag_t    in_tag, out_tag;
  fast_result_t res;

  assign in_tag = '{is_corner: in_is_corner, x: in_x, y: in_y, sof: in_sof, eof: in_eof};

  // in_ready depends combinationally on out_ready; this path is intentional.
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign score_ce  = !stall && (in_valid || (|vld));
  assign out_valid = vld[LAT-1];
  assign fire      = out_valid && out_ready;

  fast_tag_pipe #(
    .LAT (LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .en      (score_ce),
    .in_vld  (in_valid && in_ready),
    .in_tag  (in_tag),
    .vld     (vld),
    .out_tag (out_tag)
  );

  always_comb begin
    res.corner = out_tag.is_corner && (score_in >= cfg_min_score);
    res.score  = res.corner ? score_in : '0;
    res.x      = out_tag.x;
    res.y      = out_tag.y;
    res.sof    = out_tag.sof;
    res.eof    = out_tag.eof;
  end

  assign out_score  = res.score;
  assign out_corner = res.corner;
  assign out_x      = res.x;
  assign out_y      = res.y;
  assign out_sof    = res.sof;
  assign out_eof    = res.eof;

  logic [CNT_W-1:0] count_q, count_d, count_base;
  logic [CNT_W-1:0] frame_corners_q, frame_corners_d;
  logic             frame_done_q, frame_done_d;

  always_comb begin
    count_d         = count_q;
    frame_corners_d = frame_corners_q;
    frame_done_d    = 1'b0;
    count_base      = res.sof ? '0 : count_q;
    if (fire) begin
      count_d = (res.corner && !(&count_base)) ? count_base + CNT_W'(1) : count_base;
      if (res.eof) begin
        frame_corners_d = count_d;
        frame_done_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q         <= '0;
      frame_corners_q <= '0;
      frame_done_q    <= 1'b0;
    end else begin
      count_q         <= count_d;
      frame_corners_q <= frame_corners_d;
      frame_done_q    <= frame_done_d;
    end
  end

  assign frame_corners = frame_corners_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_fast_score_sched.sv
// Self-checking bench: datapath model plus a queue-based scoreboard of accepted candidates.
module tb_fast_score_sched;
  import fast_pkg::*;

  localparam int unsigned LAT = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_is_corner, in_sof, in_eof;
  logic [10:0] in_x, in_y, out_x, out_y;
  logic [12:0] cfg_min_score, score_in, out_score;
  logic        score_ce, out_valid, out_ready, out_corner, out_sof, out_eof, frame_done;
  logic [15:0] frame_corners;

  always #5 clk = ~clk;

  fast_score_sched dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_is_corner  (in_is_corner),
    .in_x          (in_x),
    .in_y          (in_y),
    .in_sof        (in_sof),
    .in_eof        (in_eof),
    .cfg_min_score (cfg_min_score),
    .score_ce      (score_ce),
    .score_in      (score_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_score     (out_score),
    .out_corner    (out_corner),
    .out_x         (out_x),
    .out_y         (out_y),
    .out_sof       (out_sof),
    .out_eof       (out_eof),
    .frame_corners (frame_corners),
    .frame_done    (frame_done)
  );

  // Score datapath model: 5 enabled stages, result = max(sum bright, sum dark).
  logic [7:0]  bright [16], dark [16], bright_n [16], dark_n [16];
  logic [12:0] cfg_n;
  logic [12:0] dp [LAT];

  function automatic int unsigned diff_score();
    int unsigned sb = 0, sd = 0;
    for (int i = 0; i < 16; i++) begin
      sb += bright[i];
      sd += dark[i];
    end
    return (sb > sd) ? sb : sd;
  endfunction

  always @(posedge clk) begin
    if (score_ce) begin
      for (int i = LAT - 1; i > 0; i--) dp[i] <= dp[i-1];
      dp[0] <= 13'(diff_score());
    end
  end
  assign score_in = dp[LAT-1];

  typedef struct {
    int unsigned t, s0;
    bit          c;
    int unsigned x, y;
    bit          sof, eof;
    int unsigned score;
  } ent_t;

  ent_t        q[$];
  int unsigned cyc = 0, stall_total = 0, count_m = 0, fc_exp = 0;
  bit          fd_exp = 0, last_acc = 0;
  int          n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_diffs(input int unsigned b, input int unsigned d);
    for (int i = 0; i < 16; i++) begin
      bright_n[i] = 8'(b);
      dark_n[i]   = 8'(d);
    end
  endtask

  // One clock cycle: drive inputs, check every output against the model, update the model.
  task automatic step(input bit v, input bit c, input int unsigned x, input int unsigned y,
                      input bit s, input bit e, input bit rdy);
    bit ov, st, ec;
    ent_t h;
    int unsigned cnt;
    @(negedge clk);
    bright = bright_n;
    dark = dark_n;
    cfg_min_score = cfg_n;
    in_valid = v; in_is_corner = c; in_x = 11'(x); in_y = 11'(y);
    in_sof = s; in_eof = e; out_ready = rdy;
    #1;
    ov = (q.size() > 0) && (cyc >= q[0].t + LAT + (stall_total - q[0].s0));
    st = ov && !rdy;
    check_eq("out_valid", out_valid, ov);
    check_eq("in_ready", in_ready, !st);
    check_eq("score_ce", score_ce, !st && (v || q.size() > 0));
    check_eq("frame_done", frame_done, fd_exp);
    check_eq("frame_corners", frame_corners, fc_exp);
    fd_exp = 0;
    if (ov && rdy) begin
      h  = q.pop_front();
      ec = h.c && (h.score >= cfg_min_score);
      check_eq("out_x", out_x, h.x);
      check_eq("out_y", out_y, h.y);
      check_eq("out_sof", out_sof, h.sof);
      check_eq("out_eof", out_eof, h.eof);
      check_eq("out_corner", out_corner, ec);
      check_eq("out_score", out_score, ec ? h.score : 0);
      cnt = (h.sof ? 0 : count_m) + ec;
      if (cnt > 65535) cnt = 65535;
      count_m = cnt;
      if (h.eof) begin
        fc_exp = cnt;
        fd_exp = 1;
      end
    end
    last_acc = v && !st;
    if (last_acc)
      q.push_back('{t: cyc, s0: stall_total, c: c, x: x, y: y, sof: s, eof: e,
                    score: diff_score()});
    if (st) stall_total++;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; in_valid = 0; out_ready = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    q.delete();
    count_m = 0; fc_exp = 0; fd_exp = 0;
  endtask

  bit fc_pat [6] = '{1, 0, 1, 1, 0, 0};

  initial begin
    int i, k;
    rst = 1; in_valid = 0; in_is_corner = 0; in_x = 0; in_y = 0; in_sof = 0; in_eof = 0;
    out_ready = 1; cfg_min_score = 0; cfg_n = 0;
    set_diffs(0, 0);
    bright = bright_n; dark = dark_n;
    do_reset();

    // Reset state, then single corner with score 16.
    idle(2);
    set_diffs(1, 0);
    step(1, 1, 10, 20, 0, 0, 1);
    idle(8);

    // Eight back-to-back, no backpressure.
    for (int j = 0; j < 8; j++) begin
      set_diffs(j + 1, j);
      step(1, 1, 100 + j, 5, 0, 0, 1);
    end
    idle(8);

    // Same stream with three stall cycles mid-burst; held candidates are re-presented.
    i = 0; k = 0;
    while (i < 8 && k < 40) begin
      set_diffs(i + 1, i);
      step(1, 1, 100 + i, 6, 0, 0, !(k inside {6, 7, 8}));
      if (last_acc) i++;
      k++;
    end
    check_eq("burst_accepted", i, 8);
    idle(10);

    // Min-score qualification: corner scoring 16 and non-corner scoring 40 both disqualified.
    cfg_n = 20;
    set_diffs(1, 0);
    step(1, 1, 1, 1, 0, 0, 1);
    set_diffs(0, 0);
    for (int j = 0; j < 8; j++) dark_n[j] = 8'd5;
    step(1, 0, 2, 1, 0, 0, 1);
    idle(7);
    cfg_n = 0;

    // Six-pixel frame with three qualified corners, then a restarted frame, then a 1-pixel frame.
    set_diffs(3, 1);
    for (int j = 0; j < 6; j++) step(1, fc_pat[j], j, 7, j == 0, j == 5, 1);
    for (int j = 0; j < 3; j++) step(1, 1, j, 8, j == 0, j == 2, 1);
    step(1, 1, 0, 9, 1, 1, 1);
    idle(8);

    // Reset with three results in flight; count must restart from zero.
    set_diffs(2, 0);
    for (int j = 0; j < 5; j++) step(1, 1, 50 + j, 3, j == 0, 0, 1);
    idle(2);
    do_reset();
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 60, 3, 0, 1, 1);
    idle(8);

    // Randomized traffic with random backpressure and config changes.
    for (int j = 0; j < 400; j++) begin
      for (int m = 0; m < 16; m++) begin
        bright_n[m] = 8'($urandom_range(0, 63));
        dark_n[m]   = 8'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 19) == 0) cfg_n = 13'($urandom_range(0, 700));
      step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, 2047),
           $urandom_range(0, 2047), $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) != 0);
    end
    k = 0;
    while (q.size() > 0 && k < 40) begin
      idle(1);
      k++;
    end
    check_eq("drain_empty", q.size(), 0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
